// File: rtl/sin_coef_fetch_if.sv
// ============================================================================
// Module   : sin_coef_fetch_if
// Brief    : Phase/coefficient-table/result bundle for the sine coefficient fetcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sin_coef_fetch_if #(
    parameter int SEG_BITS = 6
);
    logic                pushin;
    logic [31:0]         phase;
    logic                tbl_we;
    logic [SEG_BITS-1:0] tbl_addr;
    logic [1:0]          tbl_sel;
    logic [63:0]         tbl_wdata;
    logic                pushout;
    logic [63:0]         A;
    logic [63:0]         B;
    logic [63:0]         C;
    logic [63:0]         delta;

    modport master (
        output pushin, phase, tbl_we, tbl_addr, tbl_sel, tbl_wdata,
        input  pushout, A, B, C, delta
    );

    modport slave (
        input  pushin, phase, tbl_we, tbl_addr, tbl_sel, tbl_wdata,
        output pushout, A, B, C, delta
    );
endinterface

`default_nettype wire

// File: rtl/sin_coef_fetch.sv
// ============================================================================
// Module   : sin_coef_fetch
// Brief    : Folds a 32-bit phase into the first quadrant, fetches the segment's
//            A/B/C doubles and converts the residual to a double delta (3 cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_coef_fetch #(
    parameter int SEG_BITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    sin_coef_fetch_if.slave  bus
);
    localparam int          c_RW       = 30 - SEG_BITS;
    localparam int          c_PW       = $clog2(c_RW + 1);
    localparam int          c_NSEG     = 1 << SEG_BITS;
    localparam logic [10:0] c_EXP_BASE = 11'(1023 - c_RW);
    localparam logic [30:0] c_QUARTER  = 31'h4000_0000;
    localparam logic [5:0]  c_MANT_W   = 6'd52;

    logic [63:0] r_tbl_a [c_NSEG];
    logic [63:0] r_tbl_b [c_NSEG];
    logic [63:0] r_tbl_c [c_NSEG];

    logic                r_s1_valid;
    logic [SEG_BITS-1:0] r_s1_seg;
    logic [c_RW:0]       r_s1_r;
    logic                r_s1_neg;

    logic                r_s2_valid;
    logic [63:0]         r_s2_a;
    logic [63:0]         r_s2_b;
    logic [63:0]         r_s2_c;
    logic [c_RW:0]       r_s2_r;
    logic [c_PW-1:0]     r_s2_p;
    logic                r_s2_neg;

    logic [30:0]         w_xf;
    logic [SEG_BITS-1:0] w_seg;
    logic [c_RW:0]       w_r;
    logic [c_PW-1:0]     w_p;
    logic [5:0]          w_shamt;
    logic [51:0]         w_mant;
    logic [10:0]         w_exp;
    logic [63:0]         w_delta;
    logic [63:0]         w_sign;

    always_ff @(posedge clk) begin
        if (bus.tbl_we) begin
            case (bus.tbl_sel)
                2'd0:    r_tbl_a[bus.tbl_addr] <= bus.tbl_wdata;
                2'd1:    r_tbl_b[bus.tbl_addr] <= bus.tbl_wdata;
                2'd2:    r_tbl_c[bus.tbl_addr] <= bus.tbl_wdata;
                default: ;
            endcase
        end
    end

    // Odd quadrants mirror the residual; x == 0 there lands exactly on the quadrant end.
    always_comb begin
        w_xf = bus.phase[30] ? (c_QUARTER - {1'b0, bus.phase[29:0]})
                             : {1'b0, bus.phase[29:0]};
        if (w_xf[30]) begin
            w_seg = '1;
            w_r   = {1'b1, {c_RW{1'b0}}};
        end else begin
            w_seg = w_xf[29:c_RW];
            w_r   = {1'b0, w_xf[c_RW-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (bus.pushin) begin
            r_s1_seg <= w_seg;
            r_s1_r   <= w_r;
            r_s1_neg <= bus.phase[31];
        end
    end

    always_comb begin
        w_p = '0;
        for (int i = 0; i <= c_RW; i++) begin
            if (r_s1_r[i]) w_p = c_PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_s2_a   <= r_tbl_a[r_s1_seg];
            r_s2_b   <= r_tbl_b[r_s1_seg];
            r_s2_c   <= r_tbl_c[r_s1_seg];
            r_s2_r   <= r_s1_r;
            r_s2_p   <= w_p;
            r_s2_neg <= r_s1_neg;
        end
    end

    // Shifting the leading one up to bit 52 drops it, leaving the fraction field.
    always_comb begin
        w_shamt = c_MANT_W - 6'(r_s2_p);
        w_mant  = 52'(r_s2_r) << w_shamt;
        w_exp   = c_EXP_BASE + 11'(r_s2_p);
        w_delta = (r_s2_r == '0) ? 64'h0 : {1'b0, w_exp, w_mant};
        w_sign  = {r_s2_neg, 63'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            bus.pushout <= 1'b0;
            bus.A       <= 64'h0;
            bus.B       <= 64'h0;
            bus.C       <= 64'h0;
            bus.delta   <= 64'h0;
        end else begin
            r_s1_valid  <= bus.pushin;
            r_s2_valid  <= r_s1_valid;
            bus.pushout <= r_s2_valid;
            if (r_s2_valid) begin
                bus.A     <= r_s2_a ^ w_sign;
                bus.B     <= r_s2_b ^ w_sign;
                bus.C     <= r_s2_c ^ w_sign;
                bus.delta <= w_delta;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_sin_coef_fetch.sv
// ============================================================================
// Module   : tb_sin_coef_fetch
// Brief    : Directed and random scoreboard bench for sin_coef_fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sin_coef_fetch;
    localparam int SEG_BITS = 6;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sin_coef_fetch_if #(.SEG_BITS(SEG_BITS)) bus();

    sin_coef_fetch #(.SEG_BITS(SEG_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] m_a [64];
    logic [63:0] m_b [64];
    logic [63:0] m_c [64];
    int          tests = 0;
    int          fails = 0;
    int          n_out = 0;
    int          n0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Independent reference: fold in integer arithmetic, delta via real conversion.
    function automatic exp_t model(input logic [31:0] ph);
        exp_t        e;
        longint      quarter;
        longint      xf;
        longint      r;
        int          seg;
        logic [63:0] s;
        quarter = 1073741824;
        xf  = ph[30] ? (quarter - longint'(ph[29:0])) : longint'(ph[29:0]);
        seg = (xf == quarter) ? 63 : int'(xf / 16777216);
        r   = xf - longint'(seg) * 16777216;
        s   = {ph[31], 63'b0};
        e.a = m_a[seg] ^ s;
        e.b = m_b[seg] ^ s;
        e.c = m_c[seg] ^ s;
        e.d = $realtobits(real'(r) / 16777216.0);
        return e;
    endfunction

    task automatic drive(input logic push, input logic [31:0] ph, input exp_t e,
                         input logic we, input logic [5:0] addr, input logic [1:0] sel,
                         input logic [63:0] wd);
        bus.pushin    = push;
        bus.phase     = ph;
        bus.tbl_we    = we;
        bus.tbl_addr  = addr;
        bus.tbl_sel   = sel;
        bus.tbl_wdata = wd;
        if (we) begin
            case (sel)
                2'd0:    m_a[addr] = wd;
                2'd1:    m_b[addr] = wd;
                2'd2:    m_c[addr] = wd;
                default: ;
            endcase
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        bus.pushin = 1'b0;
        bus.tbl_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, '0, 1'b0, 6'd0, 2'd0, 64'h0);
    endtask

    task automatic write(input logic [5:0] addr, input logic [1:0] sel, input logic [63:0] wd);
        drive(1'b0, 32'h0, '0, 1'b1, addr, sel, wd);
    endtask

    // Called right after a single push: pushout must rise on the third cycle only.
    task automatic latency_check(input string tag);
        @(negedge clk); check({tag, "_lat1"}, 64'(bus.pushout), 64'd0);
        @(negedge clk); check({tag, "_lat2"}, 64'(bus.pushout), 64'd0);
        @(negedge clk); check({tag, "_lat3"}, 64'(bus.pushout), 64'd1);
        @(negedge clk); check({tag, "_lat4"}, 64'(bus.pushout), 64'd0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.pushout === 1'b1) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_pushout", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("A", bus.A, mon_e.a);
                check("B", bus.B, mon_e.b);
                check("C", bus.C, mon_e.c);
                check("delta", bus.delta, mon_e.d);
            end
        end
    end

    initial begin
        bus.pushin    = 1'b1;
        bus.phase     = 32'h0580_0000;
        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_sel   = 2'd0;
        bus.tbl_wdata = 64'h0;
        rst           = 1'b0;

        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_pushout", 64'(bus.pushout), 64'd0);
            check("rst_A", bus.A, 64'h0);
            check("rst_B", bus.B, 64'h0);
            check("rst_C", bus.C, 64'h0);
            check("rst_delta", bus.delta, 64'h0);
        end
        bus.pushin = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) begin
            write(6'(i), 2'd0, {$urandom, $urandom});
            write(6'(i), 2'd1, {$urandom, $urandom});
            write(6'(i), 2'd2, {$urandom, $urandom});
        end
        write(6'd5, 2'd0, 64'h3FF0_0000_0000_0000);
        write(6'd5, 2'd1, 64'h4000_0000_0000_0000);
        write(6'd5, 2'd2, 64'h4008_0000_0000_0000);
        write(6'd5, 2'd3, 64'hDEAD_BEEF_DEAD_BEEF);

        drive(1'b1, 32'h0580_0000,
              {64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
               64'h4008_0000_0000_0000, 64'h3FE0_0000_0000_0000},
              1'b0, 6'd0, 2'd0, 64'h0);
        latency_check("t2");

        drive(1'b1, 32'h8500_0000,
              {64'hBFF0_0000_0000_0000, 64'hC000_0000_0000_0000,
               64'hC008_0000_0000_0000, 64'h0},
              1'b0, 6'd0, 2'd0, 64'h0);
        idle(4);

        drive(1'b1, 32'h4000_0000, {m_a[63], m_b[63], m_c[63], 64'h3FF0_0000_0000_0000},
              1'b0, 6'd0, 2'd0, 64'h0);
        drive(1'b1, 32'h7FFF_FFFF, {m_a[0], m_b[0], m_c[0], 64'h3E70_0000_0000_0000},
              1'b0, 6'd0, 2'd0, 64'h0);
        idle(4);

        n0 = n_out;
        drive(1'b1, 32'h1111_1111, model(32'h1111_1111), 1'b0, 6'd0, 2'd0, 64'h0);
        drive(1'b1, 32'h2222_2222, model(32'h2222_2222), 1'b0, 6'd0, 2'd0, 64'h0);
        bus.pushin = 1'b1;
        bus.phase  = 32'h3333_3333;
        rst        = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.pushin = 1'b0;
        idle(6);
        check("rst_midstream_pushouts", 64'(n_out - n0), 64'd0);
        drive(1'b1, 32'h1234_5678, model(32'h1234_5678), 1'b0, 6'd0, 2'd0, 64'h0);
        latency_check("t5");

        drive(1'b1, 32'h0580_0000,
              {64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000,
               64'h4008_0000_0000_0000, 64'h3FE0_0000_0000_0000},
              1'b0, 6'd0, 2'd0, 64'h0);
        drive(1'b1, 32'h0580_0000,
              {64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000,
               64'h4008_0000_0000_0000, 64'h3FE0_0000_0000_0000},
              1'b1, 6'd5, 2'd0, 64'h4010_0000_0000_0000);
        idle(4);

        drive(1'b1, 32'hC000_0000, model(32'hC000_0000), 1'b0, 6'd0, 2'd0, 64'h0);
        drive(1'b1, 32'h0000_0000, model(32'h0000_0000), 1'b0, 6'd0, 2'd0, 64'h0);
        drive(1'b1, 32'hFFFF_FFFF, model(32'hFFFF_FFFF), 1'b0, 6'd0, 2'd0, 64'h0);
        drive(1'b1, 32'hBFFF_FFFF, model(32'hBFFF_FFFF), 1'b0, 6'd0, 2'd0, 64'h0);
        for (int k = 0; k < 24; k++) begin
            logic [31:0] ph;
            ph = $urandom;
            drive(1'b1, ph, model(ph), 1'b0, 6'd0, 2'd0, 64'h0);
        end

        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
